// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Detects load-use hazards, stalls the front end and injects bubbles; kills ID on a taken branch.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall_ext,
  input  logic              flush,
  input  logic              valid_ID,
  input  logic [XLEN-1:0]   PC_ID,
  input  logic [XLEN-1:0]   RD1_ID,
  input  logic [XLEN-1:0]   RD2_ID,
  input  logic [XLEN-1:0]   IMM_ID,
  input  logic [4:0]        RS1_ID,
  input  logic [4:0]        RS2_ID,
  input  logic [4:0]        RD_ID,
  input  logic              useRS1_ID,
  input  logic              useRS2_ID,
  input  logic [CTRL_W-1:0] ctrl_ID,
  output logic              valid_EX,
  output logic [XLEN-1:0]   PC_EX,
  output logic [XLEN-1:0]   RD1_EX,
  output logic [XLEN-1:0]   RD2_EX,
  output logic [XLEN-1:0]   IMM_EX,
  output logic [4:0]        RS1_EX,
  output logic [4:0]        RS2_EX,
  output logic [4:0]        RD_EX,
  output logic [CTRL_W-1:0] ctrl_EX,
  output logic              regWrite_EX,
  output logic              memRead_EX,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic hz;
  logic rs1_match;
  logic rs2_match;

  assign regWrite_EX = ctrl_EX[0] & valid_EX;
  assign memRead_EX  = ctrl_EX[1] & valid_EX;

  // A load writing x0 never produces a value, so it can never be a hazard.
  assign rs1_match = useRS1_ID && (RS1_ID == RD_EX);
  assign rs2_match = useRS2_ID && (RS2_ID == RD_EX);
  assign hz        = memRead_EX && (RD_EX != 5'd0) && valid_ID && !flush
                     && (rs1_match || rs2_match);

  assign PCWrite   = ~(hz | stall_ext);
  assign IFIDWrite = ~(hz | stall_ext);

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_EX   <= 1'b0;
      PC_EX      <= '0;
      RD1_EX     <= '0;
      RD2_EX     <= '0;
      IMM_EX     <= '0;
      RS1_EX     <= '0;
      RS2_EX     <= '0;
      RD_EX      <= '0;
      ctrl_EX    <= '0;
      bubble_cnt <= '0;
    end else if (!stall_ext) begin
      if (flush || hz) begin
        // Bubble: zeroed control keeps it from retriggering hazards or forwarding.
        valid_EX <= 1'b0;
        PC_EX    <= '0;
        RD1_EX   <= '0;
        RD2_EX   <= '0;
        IMM_EX   <= '0;
        RS1_EX   <= '0;
        RS2_EX   <= '0;
        RD_EX    <= '0;
        ctrl_EX  <= '0;
        if (hz && (bubble_cnt != {CNT_W{1'b1}})) begin
          bubble_cnt <= bubble_cnt + 1'b1;
        end
      end else begin
        valid_EX <= valid_ID;
        PC_EX    <= PC_ID;
        RD1_EX   <= RD1_ID;
        RD2_EX   <= RD2_ID;
        IMM_EX   <= IMM_ID;
        RS1_EX   <= RS1_ID;
        RS2_EX   <= RS2_ID;
        RD_EX    <= RD_ID;
        ctrl_EX  <= valid_ID ? ctrl_ID : '0;
      end
    end
  end

endmodule
